// File: rtl/imm_packer_if.sv
// Handshake bus for imm_packer: loader-side input word plus instruction-memory-side output.
// The block under drive uses the slave modport; the producer/consumer side uses master.
interface imm_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [31:0] imm;
    logic [1:0]  immSrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_instr;

    modport master (
        output in_valid, base_instr, imm, immSrc, out_ready,
        input  in_ready, out_valid, out_addr, out_instr
    );

    modport slave (
        input  in_valid, base_instr, imm, immSrc, out_ready,
        output in_ready, out_valid, out_addr, out_instr
    );
endinterface

// File: rtl/imm_packer.sv
// Immediate packer: inserts an immediate into an instruction word, buffers it in a 2-entry FIFO
// and emits it with a sequential address. Optional macro IMM_RANGE_CHECK_EN drops out-of-range words.
module imm_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    imm_packer_if.slave bus,
    output logic [10:0] word_count,
    output logic        done,
    output logic        range_err
);
    localparam logic [11:0] DEPTH_W = 12'(DEPTH);

    function automatic logic [31:0] pack_imm(input logic [31:0] base, input logic [31:0] imm,
                                             input logic [1:0] src);
        logic [31:0] r;
        r = base;
        case (src)
            2'b00:        r[31:20] = imm[11:0];
            2'b01, 2'b10: r[31:25] = imm[6:0];
            2'b11:        r[31:12] = imm[19:0];
            default:      r = base;
        endcase
        return r;
    endfunction

    logic [31:0] mem_r [0:1];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  occ_r;
    logic [31:0] addr_r;
    logic [10:0] count_r;
    logic [11:0] occ_plus_count_s;
    logic        in_ready_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        in_range_s;
    logic [31:0] packed_s;

    assign packed_s = pack_imm(bus.base_instr, bus.imm, bus.immSrc);

`ifdef IMM_RANGE_CHECK_EN
    // Field fits iff every bit from the field's sign position upward matches.
    function automatic logic imm_fits(input logic [31:0] imm, input logic [1:0] src);
        logic ok;
        case (src)
            2'b00:        ok = (&imm[31:11]) | ~(|imm[31:11]);
            2'b01, 2'b10: ok = (&imm[31:6])  | ~(|imm[31:6]);
            2'b11:        ok = (&imm[31:19]) | ~(|imm[31:19]);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic range_err_r;

    assign in_range_s = imm_fits(bus.imm, bus.immSrc);
    assign range_err  = range_err_r;

    // Sticky record of any accepted out-of-range immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_r <= 1'b0;
        end else if (clear) begin
            range_err_r <= 1'b0;
        end else if (accept_s && !in_range_s) begin
            range_err_r <= 1'b1;
        end else begin
            range_err_r <= range_err_r;
        end
    end
`else
    logic unused_imm_s;

    assign unused_imm_s = ^bus.imm[31:20];
    assign in_range_s   = 1'b1;
    assign range_err    = 1'b0;
`endif

    // Accept gating uses only registered state and clear, never out_ready.
    always_comb begin
        occ_plus_count_s = {10'b0, occ_r} + {1'b0, count_r};
        if ((occ_plus_count_s < DEPTH_W) && (occ_r != 2'd2) && !clear) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.in_valid && in_ready_s;
    assign push_s   = accept_s && in_range_s;
    assign pop_s    = (occ_r != 2'd0) && bus.out_ready && !clear;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (occ_r != 2'd0);
    assign bus.out_instr = mem_r[rd_ptr_r];
    assign bus.out_addr  = addr_r;
    assign word_count    = count_r;
    assign done          = ({1'b0, count_r} == DEPTH_W);

    // FIFO storage, pointers, occupancy, address and emitted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= 32'h0000_0000;
            mem_r[1] <= 32'h0000_0000;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
            addr_r   <= BASE_ADDR;
            count_r  <= 11'd0;
        end else if (clear) begin
            mem_r[0] <= 32'h0000_0000;
            mem_r[1] <= 32'h0000_0000;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
            addr_r   <= BASE_ADDR;
            count_r  <= 11'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= packed_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
                addr_r   <= addr_r + 32'd4;
                count_r  <= count_r + 11'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
                addr_r   <= addr_r;
                count_r  <= count_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end
endmodule
